// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder and the processor side.
package inst_fetch_responder_pkg;

    // Default widths shared with the processor fetch path.
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 2;

    // Opcode returned whenever no valid program data is available.
    localparam logic [7:0] NOP_OP = 8'h00;

    // Responder control states.
    typedef enum logic [1:0] {
        st_empty,
        st_load,
        st_run
    } state_e;

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Loader and fetch bus between the program loader/processor and the responder.
interface inst_fetch_responder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) ();

    logic              load_start;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instruction;
    logic              inst_valid;

    // Loader/processor side.
    modport master (
        output load_start, load_data, load_valid, address,
        input  load_ready, load_done, instruction, inst_valid
    );

    // Responder side.
    modport slave (
        input  load_start, load_data, load_valid, address,
        output load_ready, load_done, instruction, inst_valid
    );

endinterface

// File: rtl/inst_fetch_responder_store_array.sv
// DEPTH x DATA_W program store with a synchronous write port and a registered read port.
module inst_fetch_responder_store_array #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       ADDR_W = 2,
    parameter int unsigned       DEPTH  = 4,
    parameter int unsigned       PTR_W  = 2,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              rd_in_range;

    // Addresses past the last entry read back as NOP rather than aliasing.
    assign rd_in_range = 32'(rd_addr) < DEPTH;

    // Program storage; reset clears every entry to NOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= NOP;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read; a disabled read presents NOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= NOP;
        end else if (rd_en && rd_in_range) begin
            rd_q <= mem_q[rd_addr];
        end else begin
            rd_q <= NOP;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: loads a small program store over a valid/ready port,
// then answers fetch addresses with a registered instruction one clock later.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int unsigned       DATA_W = DATA_W_DEF,
    parameter int unsigned       ADDR_W = ADDR_W_DEF,
    parameter int unsigned       DEPTH  = 4,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_OP)
) (
    input logic                  clk,
    input logic                  reset_n,
    inst_fetch_responder_if.slave bus
);

    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             wr_en;
    logic             rd_en;
    logic             xfer;

    assign bus.load_ready = (state_q == st_load);
    assign xfer           = bus.load_ready && bus.load_valid;

    // State, write pointer and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= st_empty;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Next-state, pointer advance and store strobes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        valid_d = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            st_empty: begin
                if (bus.load_start) begin
                    state_d = st_load;
                    ptr_d   = '0;
                end
            end
            st_load: begin
                // load_start is deliberately ignored here, including on the last byte.
                if (xfer) begin
                    wr_en = 1'b1;
                    if (ptr_q == LAST) begin
                        ptr_d   = '0;
                        state_d = st_run;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            st_run: begin
                // A reload request wins over the fetch issued in the same cycle.
                if (bus.load_start) begin
                    state_d = st_load;
                    ptr_d   = '0;
                end else begin
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = st_empty;
                ptr_d   = '0;
            end
        endcase
    end

    inst_fetch_responder_store_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .NOP    (NOP)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (ptr_q),
        .wr_data (bus.load_data),
        .rd_en   (rd_en),
        .rd_addr (bus.address),
        .rd_data (bus.instruction)
    );

    assign bus.load_done  = done_q;
    assign bus.inst_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: a DEPTH=4 instance driven from a vector table
// plus hand sequences, and a DEPTH=3 instance for the out-of-range fetch case.
module tb_inst_fetch_responder;

    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    inst_fetch_responder_if #(.DATA_W(8), .ADDR_W(2)) b4 ();
    inst_fetch_responder_if #(.DATA_W(8), .ADDR_W(2)) b3 ();

    inst_fetch_responder #(
        .DATA_W (8),
        .ADDR_W (2),
        .DEPTH  (4),
        .NOP    (8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b4)
    );

    inst_fetch_responder #(
        .DATA_W (8),
        .ADDR_W (2),
        .DEPTH  (3),
        .NOP    (8'h00)
    ) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic [1:0] addr;
        logic       exp_ready;
        logic       exp_done;
        logic       exp_ivalid;
        logic [7:0] exp_instr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic v, input logic [7:0] d, input logic [1:0] a,
                       input logic er, input logic ed, input logic ev, input logic [7:0] ei);
        vec_t t;
        t.start = s; t.valid = v; t.data = d; t.addr = a;
        t.exp_ready = er; t.exp_done = ed; t.exp_ivalid = ev; t.exp_instr = ei;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic er, input logic ed, input logic ev,
                        input logic [7:0] ei);
        chk({tag, "_ready"}, 32'(b4.load_ready), 32'(er));
        chk({tag, "_done"}, 32'(b4.load_done), 32'(ed));
        chk({tag, "_ivalid"}, 32'(b4.inst_valid), 32'(ev));
        chk({tag, "_instr"}, 32'(b4.instruction), 32'(ei));
    endtask

    task automatic chk3(input string tag, input logic er, input logic ed, input logic ev,
                        input logic [7:0] ei);
        chk({tag, "_ready"}, 32'(b3.load_ready), 32'(er));
        chk({tag, "_done"}, 32'(b3.load_done), 32'(ed));
        chk({tag, "_ivalid"}, 32'(b3.inst_valid), 32'(ev));
        chk({tag, "_instr"}, 32'(b3.instruction), 32'(ei));
    endtask

    // Apply one cycle of inputs, then sample just after the clock edge.
    task automatic drive4(input logic s, input logic v, input logic [7:0] d, input logic [1:0] a);
        @(negedge clk);
        b4.load_start = s; b4.load_valid = v; b4.load_data = d; b4.address = a;
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic s, input logic v, input logic [7:0] d, input logic [1:0] a);
        @(negedge clk);
        b3.load_start = s; b3.load_valid = v; b3.load_data = d; b3.address = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: inputs for one cycle, outputs expected just after that cycle's edge.
        // Full load A1..D4 and fetch
        add(1, 0, 8'h00, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'hA1, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'hB2, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'hC3, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'hD4, 0, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 1, 8'hA1);
        add(0, 0, 8'h00, 1, 0, 0, 1, 8'hB2);
        add(0, 0, 8'h00, 2, 0, 0, 1, 8'hC3);
        add(0, 0, 8'h00, 3, 0, 0, 1, 8'hD4);
        // Reload from RUN: the concurrent fetch is discarded
        add(1, 0, 8'h00, 3, 1, 0, 0, 8'h00);
        add(0, 1, 8'h55, 3, 1, 0, 0, 8'h00);
        add(0, 1, 8'h66, 3, 1, 0, 0, 8'h00);
        add(0, 1, 8'h77, 3, 1, 0, 0, 8'h00);
        add(0, 1, 8'h88, 3, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 1, 0, 0, 1, 8'h66);
        add(0, 0, 8'h00, 0, 0, 0, 1, 8'h55);
        // Stalled handshake 1,0,0,1,1,0,1 with junk data and a stray start in LOAD
        add(1, 0, 8'h00, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'h11, 0, 1, 0, 0, 8'h00);
        add(0, 0, 8'hEE, 0, 1, 0, 0, 8'h00);
        add(1, 0, 8'hEE, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'h22, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'h33, 0, 1, 0, 0, 8'h00);
        add(0, 0, 8'hEE, 0, 1, 0, 0, 8'h00);
        add(0, 1, 8'h44, 0, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 1, 8'h11);
        add(0, 0, 8'h00, 1, 0, 0, 1, 8'h22);
        add(0, 0, 8'h00, 2, 0, 0, 1, 8'h33);
        add(0, 0, 8'h00, 3, 0, 0, 1, 8'h44);
        add(0, 0, 8'h00, 3, 0, 0, 1, 8'h44);

        b4.load_start = 1'b0; b4.load_valid = 1'b0; b4.load_data = '0; b4.address = 2'd2;
        b3.load_start = 1'b0; b3.load_valid = 1'b0; b3.load_data = '0; b3.address = 2'd0;

        // Reset then idle
        reset_n = 1'b0;
        #1;
        chk4("rst", 0, 0, 0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk4($sformatf("idle%0d", i), 0, 0, 0, 8'h00);
        end

        // Table-driven load/fetch/reload/stall sequences
        for (int i = 0; i < vq.size(); i++) begin
            drive4(vq[i].start, vq[i].valid, vq[i].data, vq[i].addr);
            chk4($sformatf("v%0d", i), vq[i].exp_ready, vq[i].exp_done, vq[i].exp_ivalid,
                 vq[i].exp_instr);
        end

        // Reset in the middle of a load
        drive4(1, 0, 8'h00, 0);
        chk4("ml_start", 1, 0, 0, 8'h00);
        drive4(0, 1, 8'hA5, 0);
        drive4(0, 1, 8'h5A, 0);
        @(negedge clk);
        b4.load_start = 1'b0; b4.load_valid = 1'b0; b4.load_data = '0;
        reset_n = 1'b0;
        #1;
        chk4("ml_rst", 0, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive4(0, 0, 8'h00, 0);
            chk4($sformatf("ml_empty%0d", i), 0, 0, 0, 8'h00);
        end
        drive4(1, 0, 8'h00, 0);
        chk4("ml_reload", 1, 0, 0, 8'h00);
        drive4(0, 1, 8'h9A, 0);
        drive4(0, 1, 8'h9B, 0);
        drive4(0, 1, 8'h9C, 0);
        chk4("ml_b2", 1, 0, 0, 8'h00);
        drive4(0, 1, 8'h9D, 0);
        chk4("ml_done", 0, 1, 0, 8'h00);
        drive4(0, 0, 8'h00, 2);
        chk4("ml_f2", 0, 0, 1, 8'h9C);
        drive4(0, 0, 8'h00, 0);
        chk4("ml_f0", 0, 0, 1, 8'h9A);
        drive4(0, 0, 8'h00, 3);
        chk4("ml_f3", 0, 0, 1, 8'h9D);

        // DEPTH=3: start held on the final byte is ignored, address 3 reads NOP
        chk3("d3_empty", 0, 0, 0, 8'h00);
        drive3(1, 0, 8'h00, 0);
        chk3("d3_start", 1, 0, 0, 8'h00);
        drive3(0, 1, 8'h01, 0);
        drive3(0, 1, 8'h02, 0);
        chk3("d3_b1", 1, 0, 0, 8'h00);
        drive3(1, 1, 8'h03, 0);
        chk3("d3_done", 0, 1, 0, 8'h00);
        drive3(0, 0, 8'h00, 3);
        chk3("d3_oor", 0, 0, 1, 8'h00);
        drive3(0, 0, 8'h00, 2);
        chk3("d3_f2", 0, 0, 1, 8'h03);
        drive3(0, 0, 8'h00, 0);
        chk3("d3_f0", 0, 0, 1, 8'h01);
        drive3(0, 0, 8'h00, 1);
        chk3("d3_f1", 0, 0, 1, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
Instruction-memory responder that answers the processor's fetch requests: it takes the `address` driven by the processor and returns the registered 8-bit `instruction`.
- Holds a small program store, loaded byte-by-byte over a valid/ready load port after reset, or on request.
- Sits between the board-level program loader (switches or serial front end) and the processor's fetch interface.

Parameters:
- DATA_W, 8, instruction/byte width.
- ADDR_W, 2, fetch address width.
- DEPTH, 4, number of stored instructions; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- NOP, 8'h00, value returned when no valid instruction is available.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  request to (re)load the program store.
- load_data  in  DATA_W  program byte to write.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  responder accepts a byte this cycle.
- load_done  out  1  one-cycle pulse after the last byte is written.
- address  in  ADDR_W  fetch address from the processor.
- instruction  out  DATA_W  fetched instruction, registered.
- inst_valid  out  1  instruction holds valid program data.

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous, active-low.
- Reset (reset_n = 0, effective immediately):
  - state = EMPTY, wr_ptr = 0.
  - All DEPTH entries = NOP.
  - instruction = NOP, inst_valid = 0, load_ready = 0, load_done = 0.
- States: EMPTY, LOAD, RUN.
- EMPTY:
  - instruction = NOP, inst_valid = 0.
  - load_start = 1 -> LOAD next cycle, wr_ptr = 0, load_ready = 1 from that cycle.
- LOAD:
  - A transfer occurs when load_valid && load_ready: mem[wr_ptr] <= load_data, wr_ptr increments.
  - No transfer: nothing changes. load_data is ignored unless load_valid = 1.
  - On the transfer with wr_ptr = DEPTH-1:
    - wr_ptr wraps to 0.
    - Next cycle: load_ready = 0, load_done = 1 for exactly one cycle, state = RUN.
  - load_start asserted while in LOAD is ignored; it does not restart the pointer.
  - instruction = NOP, inst_valid = 0 throughout LOAD.
- RUN, fetch path:
  - Every cycle, instruction <= mem[address] and inst_valid <= 1.
  - Latency is exactly 1 clock from `address` to `instruction`.
  - Fetches are back-to-back; there is no stall.
  - address >= DEPTH: instruction <= NOP, inst_valid stays 1.
- RUN, reload:
  - load_start = 1 -> LOAD next cycle.
  - In that cycle: inst_valid = 0, instruction = NOP, wr_ptr = 0, load_ready = 1.
  - Old contents persist until overwritten.
- Simultaneous events:
  - load_start in the same cycle as the final LOAD transfer: ignored; go to RUN.
  - load_start and a fetch in the same RUN cycle: the reload wins; the fetch result is discarded (NOP).
- Reset mid-load: return to EMPTY, partial contents cleared to NOP, no load_done pulse.
- Widths: wr_ptr is clog2(DEPTH) bits, minimum 1. Compare to DEPTH-1 explicitly; no reliance on natural overflow.
- Memory write and fetch read use the same clock edge; there is no read-during-write case, because fetch is disabled in LOAD.

Decomposition:
- Shared package (proc_pkg):
  - state enumeration (EMPTY, LOAD, RUN).
  - NOP opcode constant.
  - DATA_W / ADDR_W defaults, shared with the processor.
- One sub-module, inst_store_array:
  - DEPTH x DATA_W register array.
  - Synchronous write port and registered read port.
  - Async reset clears all entries to NOP.
- Top level holds the FSM, write pointer and handshake.

Test Plan:
1. Reset then idle:
   - Hold reset_n = 0 for 3 cycles, release, drive address = 2.
   - Expect instruction = 8'h00, inst_valid = 0, load_ready = 0 for 10 cycles.
2. Full load and fetch:
   - load_start pulse, then bytes A1, B2, C3, D4 with load_valid = 1 on consecutive cycles.
   - Expect load_done pulse one cycle after D4.
   - Then address 0,1,2,3 yields A1, B2, C3, D4, each one cycle later, with inst_valid = 1.
3. Handshake stalls:
   - Load 11, 22, 33, 44 with load_valid toggling 1,0,0,1,1,0,1.
   - Expect exactly 4 writes and correct contents.
   - No write in load_valid = 0 cycles; load_done asserted once.
4. Reload from RUN:
   - After test 2, pulse load_start.
   - Expect inst_valid = 0 the next cycle.
   - Load 55, 66, 77, 88; address 1 then returns 66.
5. Reset mid-load:
   - Write 2 of 4 bytes, then assert reset_n = 0.
   - After release, expect state EMPTY, no load_done, inst_valid = 0.
   - Fresh load of 4 bytes works from wr_ptr = 0.
6. Out-of-range address:
   - DEPTH = 3, ADDR_W = 2; load 01, 02, 03; fetch address 3.
   - Expect instruction = 8'h00 with inst_valid = 1.
   - Ignored-start check: load_start on the final byte's cycle still yields RUN.
